// File: rtl/unidade_busca_pc_if.sv
// Bus between the control unit and the PC/fetch unit: PC-source select, halt,
// branch target and front-panel button in; PC, release pulse, wait flag and counter out.
interface unidade_busca_pc_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
);
  logic [1:0]        controle_MUX4;
  logic              HALT;
  logic              zero_alu;
  logic [ADDR_W-1:0] alvo;
  logic              botao_fisico;
  logic [ADDR_W-1:0] pc;
  logic              botao;
  logic              parado;
  logic [CNT_W-1:0]  instr_count;

  modport master (
    output controle_MUX4, HALT, zero_alu, alvo, botao_fisico,
    input  pc, botao, parado, instr_count
  );

  modport slave (
    input  controle_MUX4, HALT, zero_alu, alvo, botao_fisico,
    output pc, botao, parado, instr_count
  );
endinterface

// File: rtl/unidade_busca_pc.sv
// Program counter, next-PC selection and halt/button wait sequencing.
// Optional button debounce is built when BUSCA_DEBOUNCE_EN is defined.
module unidade_busca_pc #(
  parameter int          ADDR_W          = 10,
  parameter int unsigned RESET_PC        = 0,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          CNT_W           = 16
) (
  input  logic              clock,
  input  logic              reset,
  unidade_busca_pc_if.slave bus
);

  typedef enum logic [1:0] {EXEC, ESPERA, LIBERA} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  instr_count;
  logic              botao;
  logic              parado;
  logic              btn_p0;
  logic              btn_p1;
  logic              btn_prev;
  logic              btn_acc;
  logic              btn_rise;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] cur);
    return cur + ADDR_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] next_pc(input logic [1:0]        sel,
                                                input logic              z,
                                                input logic [ADDR_W-1:0] cur,
                                                input logic [ADDR_W-1:0] tgt);
    logic [ADDR_W-1:0] r;
    case (sel)
      2'b01:   r = z  ? tgt : pc_inc(cur);
      2'b10:   r = !z ? tgt : pc_inc(cur);
      2'b11:   r = tgt;
      default: r = pc_inc(cur);
    endcase
    return r;
  endfunction

  // Button synchroniser (btn_p1 is the synchronised level btn_s)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
    end else begin
      btn_p0 <= bus.botao_fisico;
      btn_p1 <= btn_p0;
    end
  end

`ifdef BUSCA_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DEB_W-1:0] deb_cnt;
  logic             deb_level;

  // Accept a new level only after it has held for DEBOUNCE_CYCLES samples
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb_cnt   <= '0;
      deb_level <= 1'b0;
    end else if (btn_p1 == deb_level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
      deb_level <= btn_p1;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  assign btn_acc = deb_level;
`else
  assign btn_acc = btn_p1;
`endif

  assign btn_rise = btn_acc & ~btn_prev;

  // Sequencer: pc, counter and the botao/parado flags are all registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= EXEC;
      pc          <= ADDR_W'(RESET_PC);
      instr_count <= '0;
      botao       <= 1'b0;
      parado      <= 1'b0;
      btn_prev    <= 1'b0;
    end else begin
      btn_prev <= btn_acc;
      case (state)
        EXEC: begin
          botao <= 1'b0;
          if (bus.HALT) begin
            state  <= ESPERA;
            parado <= 1'b1;
          end else begin
            pc          <= next_pc(bus.controle_MUX4, bus.zero_alu, pc, bus.alvo);
            instr_count <= sat_inc(instr_count);
            parado      <= 1'b0;
          end
        end
        ESPERA: begin
          if (btn_rise) begin
            state  <= LIBERA;
            botao  <= 1'b1;
            parado <= 1'b0;
          end else begin
            botao  <= 1'b0;
            parado <= 1'b1;
          end
        end
        LIBERA: begin
          botao <= 1'b0;
          // HALT still high here is a control fault: keep waiting
          if (bus.HALT) begin
            state  <= ESPERA;
            parado <= 1'b1;
          end else begin
            state       <= EXEC;
            pc          <= pc_inc(pc);
            instr_count <= sat_inc(instr_count);
            parado      <= 1'b0;
          end
        end
        default: begin
          state  <= EXEC;
          botao  <= 1'b0;
          parado <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc          = pc;
  assign bus.botao       = botao;
  assign bus.parado      = parado;
  assign bus.instr_count = instr_count;

endmodule

// File: tb/tb_unidade_busca_pc.sv
// Directed-vector bench for unidade_busca_pc: sequencing, branches, wrap,
// halt/button release, held button, control fault, reset mid-wait, saturation.
module tb_unidade_busca_pc;

  localparam int ADDR_W = 10;
  localparam int CNT_W  = 4;
  localparam int DEB    = 16;
`ifdef BUSCA_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif
  localparam int SETTLE = LAT + 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  unidade_busca_pc_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  unidade_busca_pc #(
    .ADDR_W(ADDR_W), .RESET_PC(0), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int pulses;
    bus.controle_MUX4 = 2'b00;
    bus.HALT          = 1'b0;
    bus.zero_alu      = 1'b0;
    bus.alvo          = '0;
    bus.botao_fisico  = 1'b0;
    #2 reset = 1'b1;
    tick();
    tick();
    chk("rst_pc", 32'(bus.pc), 0);
    chk("rst_botao", 32'(bus.botao), 0);
    chk("rst_parado", 32'(bus.parado), 0);
    chk("rst_cnt", 32'(bus.instr_count), 0);
    reset = 1'b0;

    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("seq_pc", 32'(bus.pc), 32'(i));
    end
    chk("seq_cnt", 32'(bus.instr_count), 5);

    bus.controle_MUX4 = 2'b01; bus.alvo = 10'h03A; bus.zero_alu = 1'b1;
    tick(); chk("bz_taken", 32'(bus.pc), 32'h03A);
    bus.zero_alu = 1'b0;
    tick(); chk("bz_not", 32'(bus.pc), 32'h03B);
    bus.controle_MUX4 = 2'b10; bus.alvo = 10'h100; bus.zero_alu = 1'b0;
    tick(); chk("bnz_taken", 32'(bus.pc), 32'h100);
    bus.zero_alu = 1'b1;
    tick(); chk("bnz_not", 32'(bus.pc), 32'h101);
    bus.controle_MUX4 = 2'b11; bus.alvo = 10'h3FF; bus.zero_alu = 1'b0;
    tick(); chk("jump", 32'(bus.pc), 32'h3FF);
    bus.controle_MUX4 = 2'b00;
    tick(); chk("wrap", 32'(bus.pc), 32'h000);
    chk("cnt_11", 32'(bus.instr_count), 11);
    bus.controle_MUX4 = 2'b11; bus.alvo = 10'h007;
    tick(); chk("jump7", 32'(bus.pc), 7);

    // Halt opcode: HALT with a jump select must hold pc
    bus.HALT = 1'b1; bus.alvo = 10'h200;
    tick();
    chk("halt_pc", 32'(bus.pc), 7);
    chk("halt_parado", 32'(bus.parado), 1);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("wait_pc", 32'(bus.pc), 7);
      chk("wait_botao", 32'(bus.botao), 0);
    end
    bus.botao_fisico = 1'b1;
    for (int i = 0; i < LAT - 1; i++) begin
      tick(); chk("press_early", 32'(bus.botao), 0);
    end
    tick();
    chk("rel_botao", 32'(bus.botao), 1);
    chk("rel_parado", 32'(bus.parado), 0);
    chk("rel_pc", 32'(bus.pc), 7);
    bus.HALT = 1'b0; bus.controle_MUX4 = 2'b00;
    tick();
    chk("after_botao", 32'(bus.botao), 0);
    chk("after_pc", 32'(bus.pc), 8);
    chk("after_parado", 32'(bus.parado), 0);
    chk("after_cnt", 32'(bus.instr_count), 13);

    // Button already held when the wait starts
    bus.HALT = 1'b1;
    tick(); chk("held_parado", 32'(bus.parado), 1);
    for (int i = 0; i < SETTLE; i++) begin
      tick(); chk("held_botao", 32'(bus.botao), 0);
    end
    bus.botao_fisico = 1'b0;
    for (int i = 0; i < SETTLE; i++) begin
      tick(); chk("released_botao", 32'(bus.botao), 0);
    end
    bus.botao_fisico = 1'b1;
    for (int i = 0; i < LAT - 1; i++) tick();
    tick(); chk("repress_botao", 32'(bus.botao), 1);
    // HALT left high in LIBERA: back to waiting, pc holds
    tick();
    chk("fault_parado", 32'(bus.parado), 1);
    chk("fault_botao", 32'(bus.botao), 0);
    chk("fault_pc", 32'(bus.pc), 8);
    bus.botao_fisico = 1'b0;
    for (int i = 0; i < SETTLE; i++) tick();
    bus.botao_fisico = 1'b1;
    for (int i = 0; i < LAT - 1; i++) tick();
    tick(); chk("fault_rel", 32'(bus.botao), 1);
    bus.HALT = 1'b0;
    tick();
    chk("fault_pc9", 32'(bus.pc), 9);
    chk("fault_cnt", 32'(bus.instr_count), 14);

    // Reset in the middle of a wait with a press in flight
    bus.HALT = 1'b1;
    bus.botao_fisico = 1'b0;
    tick(); chk("esp_parado", 32'(bus.parado), 1);
    for (int i = 0; i < SETTLE; i++) tick();
    bus.botao_fisico = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_pc", 32'(bus.pc), 0);
    chk("mid_rst_parado", 32'(bus.parado), 0);
    chk("mid_rst_botao", 32'(bus.botao), 0);
    bus.HALT = 1'b0; bus.controle_MUX4 = 2'b00;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); chk("post_rst_botao", 32'(bus.botao), 0);
    end
    chk("post_rst_pc", 32'(bus.pc), 5);
    chk("post_rst_cnt", 32'(bus.instr_count), 5);

    for (int i = 0; i < 15; i++) tick();
    chk("sat_cnt", 32'(bus.instr_count), 15);
    chk("sat_pc", 32'(bus.pc), 20);

`ifdef BUSCA_DEBOUNCE_EN
    bus.botao_fisico = 1'b0;
    for (int i = 0; i < SETTLE; i++) tick();
    bus.HALT = 1'b1;
    tick();
    pulses = 0;
    bus.botao_fisico = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); if (bus.botao) pulses++;
    end
    bus.botao_fisico = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(); if (bus.botao) pulses++;
    end
    chk("glitch_pulses", 32'(pulses), 0);
    chk("glitch_parado", 32'(bus.parado), 1);
    bus.botao_fisico = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (i == 20) bus.botao_fisico = 1'b0;
      if (bus.botao) begin
        pulses++;
        bus.HALT = 1'b0;
      end
    end
    chk("deb_pulses", 32'(pulses), 1);
    chk("deb_parado", 32'(bus.parado), 0);
`else
    pulses = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
